// File: rtl/mb_scan_ctrl.sv
// Macroblock raster-scan sequencer: walks x,y over an mb_w x mb_h frame, handshakes
// each MB with the compute engine and strobes the boundary saver after each one.
module mb_scan_ctrl #(
    parameter int PREP_CYC = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [9:0]  mb_w,
    input  logic [9:0]  mb_h,
    output logic        mb_req,
    input  logic        mb_ack,
    input  logic        mb_done,
    output logic        sb_load,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [9:0]  w1,
    output logic [9:0]  w2,
    output logic [9:0]  h1,
    output logic [19:0] mb_cnt,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [5:0] S_IDLE = 6'b000001;
    localparam logic [5:0] S_PREP = 6'b000010;
    localparam logic [5:0] S_REQ  = 6'b000100;
    localparam logic [5:0] S_RUN  = 6'b001000;
    localparam logic [5:0] S_SAVE = 6'b010000;
    localparam logic [5:0] S_DONE = 6'b100000;

    localparam int CW = (PREP_CYC > 1) ? $clog2(PREP_CYC) : 1;
    localparam logic [CW-1:0] PREP_LAST = CW'(PREP_CYC - 1);

    logic [5:0]    state;
    logic [CW-1:0] pcnt;
    logic          last_mb;

    assign last_mb = (x == w1) && (y == h1);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pcnt       <= '0;
            x          <= '0;
            y          <= '0;
            w1         <= '0;
            w2         <= '0;
            h1         <= '0;
            mb_cnt     <= '0;
            mb_req     <= 1'b0;
            sb_load    <= 1'b0;
            frame_done <= 1'b0;
        end else if (abort && state != S_IDLE) begin
            // abort wins over any handshake in the same cycle; counters keep their value
            state      <= S_IDLE;
            mb_req     <= 1'b0;
            sb_load    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && mb_w != 10'd0 && mb_h != 10'd0) begin
                        w1     <= mb_w - 10'd1;
                        w2     <= mb_w - 10'd2;
                        h1     <= mb_h - 10'd1;
                        x      <= '0;
                        y      <= '0;
                        mb_cnt <= '0;
                        pcnt   <= '0;
                        state  <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (pcnt == PREP_LAST) begin
                        state  <= S_REQ;
                        mb_req <= 1'b1;
                    end else begin
                        pcnt <= pcnt + CW'(1);
                    end
                end
                S_REQ: begin
                    if (mb_ack) begin
                        mb_req <= 1'b0;
                        if (mb_done) begin
                            state   <= S_SAVE;
                            sb_load <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (mb_done) begin
                        state   <= S_SAVE;
                        sb_load <= 1'b1;
                    end
                end
                S_SAVE: begin
                    sb_load <= 1'b0;
                    mb_cnt  <= mb_cnt + 20'd1;
                    // the final MB keeps its position so DONE still reports it
                    if (last_mb) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                    end else begin
                        state <= S_PREP;
                        pcnt  <= '0;
                        if (x != w1) begin
                            x <= x + 10'd1;
                        end else begin
                            x <= '0;
                            y <= y + 10'd1;
                        end
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mb_scan_ctrl.sv
// Scoreboard bench for mb_scan_ctrl: a raster-order reference list is queued per frame
// and a monitor pops it on every sb_load / frame_done the DUT presents.
module tb_mb_scan_ctrl;

    localparam int PREP_CYC = 3;

    logic        clk, rst_n, start, abort;
    logic [9:0]  mb_w, mb_h;
    logic        mb_req, mb_ack, mb_done, sb_load, busy, frame_done;
    logic [9:0]  x, y, w1, w2, h1;
    logic [19:0] mb_cnt;

    logic eng_ack, eng_done, man_ack, man_done;
    assign mb_ack  = eng_ack | man_ack;
    assign mb_done = eng_done | man_done;

    mb_scan_ctrl #(.PREP_CYC(PREP_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .mb_w(mb_w), .mb_h(mb_h), .mb_req(mb_req), .mb_ack(mb_ack),
        .mb_done(mb_done), .sb_load(sb_load), .x(x), .y(y),
        .w1(w1), .w2(w2), .h1(h1), .mb_cnt(mb_cnt), .busy(busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [9:0] x; logic [9:0] y; logic [19:0] cnt; } mb_exp_t;
    typedef struct { int n; logic [9:0] x; logic [9:0] y; } frm_exp_t;

    mb_exp_t  exp_q[$];
    frm_exp_t frm_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int grants = 0;
    bit eng_en = 1'b0;
    int ack_lo = 0, ack_hi = 0, done_max = 0, co_pct = 0;
    logic [9:0] last_w1 = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    // Monitor: compares every presented save/frame event against the queued model
    logic       prev_req = 1'b0, prev_sb = 1'b0;
    logic [9:0] px = '0, py = '0;
    always @(negedge clk) begin
        mb_exp_t  e;
        frm_exp_t f;
        if (sb_load) begin
            check("sb_load_width", {31'd0, prev_sb}, 32'd0);
            if (exp_q.size() == 0) check("unexpected_sb_load", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("save_x", {22'd0, x}, {22'd0, e.x});
                check("save_y", {22'd0, y}, {22'd0, e.y});
                check("save_cnt", {12'd0, mb_cnt}, {12'd0, e.cnt});
            end
        end
        if (frame_done) begin
            if (frm_q.size() == 0) check("unexpected_frame_done", 32'd1, 32'd0);
            else begin
                f = frm_q.pop_front();
                check("done_cnt", {12'd0, mb_cnt}, 32'(f.n));
                check("done_x", {22'd0, x}, {22'd0, f.x});
                check("done_y", {22'd0, y}, {22'd0, f.y});
                check("done_grants", 32'(grants), 32'(f.n));
            end
        end
        if (mb_req && prev_req) begin
            check("req_hold_x", {22'd0, x}, {22'd0, px});
            check("req_hold_y", {22'd0, y}, {22'd0, py});
        end
        if (mb_req && !prev_req) grants++;
        prev_req = mb_req;
        prev_sb  = sb_load;
        px = x;
        py = y;
    end

    // Engine model: random ack/done latency, optionally ack and done together
    initial begin
        int a, d;
        bit co;
        eng_ack = 1'b0;
        eng_done = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_en && rst_n && mb_req) begin
                a  = $urandom_range(ack_hi, ack_lo);
                d  = $urandom_range(done_max, 0);
                co = ($urandom_range(99, 0) < co_pct);
                repeat (a) @(negedge clk);
                eng_ack = 1'b1;
                if (co) eng_done = 1'b1;
                @(negedge clk);
                eng_ack = 1'b0;
                if (!co) begin
                    repeat (d) @(negedge clk);
                    eng_done = 1'b1;
                    @(negedge clk);
                end
                eng_done = 1'b0;
                check("save_after_done", {31'd0, sb_load}, 32'd1);
            end
        end
    end

    task automatic push_frame(input int w, input int h);
        mb_exp_t  e;
        frm_exp_t f;
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++) begin
                e.x = 10'(xx); e.y = 10'(yy); e.cnt = 20'(yy * w + xx);
                exp_q.push_back(e);
            end
        f.n = w * h; f.x = 10'(w - 1); f.y = 10'(h - 1);
        frm_q.push_back(f);
    endtask

    task automatic pulse_start(input int w, input int h);
        @(negedge clk);
        grants = 0;
        mb_w = 10'(w); mb_h = 10'(h); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mb_w = 10'($urandom); mb_h = 10'($urandom);
    endtask

    task automatic run_frame(input int w, input int h, input int alo, input int ahi,
                             input int dmax, input int cpct, input bit busy_start);
        logic [9:0] ew1, ew2, eh1;
        bit seen;
        ew1 = 10'(w - 1); ew2 = 10'(w - 2); eh1 = 10'(h - 1);
        ack_lo = alo; ack_hi = ahi; done_max = dmax; co_pct = cpct; eng_en = 1'b1;
        push_frame(w, h);
        pulse_start(w, h);
        // now in cycle 1 after the start edge
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("w1", {22'd0, w1}, {22'd0, ew1});
        check("w2", {22'd0, w2}, {22'd0, ew2});
        check("h1", {22'd0, h1}, {22'd0, eh1});
        check("start_xy", {12'd0, x, y}, 32'd0);
        check("start_cnt", {12'd0, mb_cnt}, 32'd0);
        for (int c = 1; c <= PREP_CYC + 1; c++) begin
            check("req_timing", {31'd0, mb_req}, {31'd0, (c == PREP_CYC + 1)});
            if (c <= PREP_CYC) @(negedge clk);
        end
        if (busy_start) begin
            @(negedge clk);
            mb_w = 10'd9; mb_h = 10'd9; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("busy_start_w1", {22'd0, w1}, {22'd0, ew1});
            check("busy_start_h1", {22'd0, h1}, {22'd0, eh1});
        end
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        check("frame_done_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
        check("idle_after_done", {30'd0, busy, frame_done}, 32'd0);
        check("final_cnt", {12'd0, mb_cnt}, 32'(w * h));
        check("final_xy", {12'd0, x, y}, {12'd0, 10'(w - 1), 10'(h - 1)});
        check("queues_drained", 32'(exp_q.size() + frm_q.size()), 32'd0);
        last_w1 = ew1;
        eng_en = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (mb_req) seen = 1'b1;
            else @(negedge clk);
        end
        check(nm, {31'd0, seen}, 32'd1);
    endtask

    function automatic logic all_zero();
        return ({x, y, w1, w2, h1, mb_cnt, mb_req, sb_load, busy, frame_done} == '0);
    endfunction

    initial begin
        mb_mb_init: begin
            rst_n = 1'b0; start = 1'b0; abort = 1'b0;
            mb_w = '0; mb_h = '0; man_ack = 1'b0; man_done = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("reset_outputs", {31'd0, all_zero()}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {31'd0, busy}, 32'd0);

        // 2x2 frame, ack one cycle after request, done five later
        run_frame(2, 2, 1, 1, 4, 0, 1'b0);
        // single column: w2 wraps
        run_frame(1, 3, 0, 2, 3, 0, 1'b0);
        // long ack delay, then ack+done coinciding
        run_frame(1, 2, 7, 7, 2, 0, 1'b0);
        run_frame(2, 1, 0, 1, 0, 100, 1'b0);
        // start while busy must be ignored
        run_frame(3, 2, 0, 3, 3, 30, 1'b1);

        // zero dimension starts
        pulse_start(5, 0);
        check("zero_h_busy", {31'd0, busy}, 32'd0);
        check("zero_h_w1", {22'd0, w1}, {22'd0, last_w1});
        pulse_start(0, 4);
        check("zero_w_busy", {31'd0, busy}, 32'd0);

        for (int k = 0; k < 4; k++)
            run_frame($urandom_range(4, 1), $urandom_range(3, 1), 0, 3, 4, 25, 1'b0);

        // abort in RUN together with mb_done, after one completed MB
        begin
            mb_exp_t e;
            e.x = 10'd0; e.y = 10'd0; e.cnt = 20'd0;
            exp_q.push_back(e);
        end
        pulse_start(2, 2);
        wait_req("abort_req1");
        man_ack = 1'b1; @(negedge clk); man_ack = 1'b0;
        repeat (2) @(negedge clk);
        man_done = 1'b1; @(negedge clk); man_done = 1'b0;
        wait_req("abort_req2");
        man_ack = 1'b1; @(negedge clk); man_ack = 1'b0;
        @(negedge clk);
        abort = 1'b1; man_done = 1'b1;
        @(negedge clk);
        abort = 1'b0; man_done = 1'b0;
        check("abort_idle", {31'd0, busy}, 32'd0);
        check("abort_outs", {29'd0, mb_req, sb_load, frame_done}, 32'd0);
        check("abort_cnt", {12'd0, mb_cnt}, 32'd1);
        repeat (8) @(negedge clk);
        check("abort_quiet", {31'd0, busy}, 32'd0);
        check("abort_queues", 32'(exp_q.size() + frm_q.size()), 32'd0);

        // reset during SAVE, then a 1x1 frame
        ack_lo = 0; ack_hi = 1; done_max = 2; co_pct = 0; eng_en = 1'b1;
        push_frame(2, 2);
        pulse_start(2, 2);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                if (sb_load) seen = 1'b1;
            end
            check("rst_save_seen", {31'd0, seen}, 32'd1);
        end
        #2 rst_n = 1'b0;
        eng_en = 1'b0;
        exp_q.delete();
        frm_q.delete();
        #1 check("midframe_reset_outs", {31'd0, all_zero()}, 32'd1);
        repeat (3) @(negedge clk);
        check("reset_hold_outs", {31'd0, all_zero()}, 32'd1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("no_event_after_reset", {30'd0, sb_load, frame_done}, 32'd0);
        run_frame(1, 1, 0, 2, 2, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mb_scan_ctrl.md
MB_SCAN_CTRL -- requirements
Module: mb_scan_ctrl

Interface
REQ-001 SHALL have parameter PREP_CYC, default 3: idle cycles before each MB request, covering the top-boundary RAM fetch latency.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: frame start pulse; honoured only in IDLE.
REQ-005 SHALL have port abort, input, 1 bit: synchronous frame abort.
REQ-006 SHALL have port mb_w, input, 10 bits: frame width in macroblocks; sampled at an accepted start.
REQ-007 SHALL have port mb_h, input, 10 bits: frame height in macroblocks; sampled at an accepted start.
REQ-008 SHALL have port mb_req, output, 1 bit: request to the MB compute engine for the current x,y.
REQ-009 SHALL have port mb_ack, input, 1 bit: engine accepted the request.
REQ-010 SHALL have port mb_done, input, 1 bit: engine finished the current MB; reconstructed Y/UV valid.
REQ-011 SHALL have port sb_load, output, 1 bit: one-cycle load strobe to the boundary saver.
REQ-012 SHALL have ports x and y, output, 10 bits each: current MB column and row.
REQ-013 SHALL have ports w1, w2 and h1, output, 10 bits each: mb_w-1, mb_w-2 and mb_h-1, registered.
REQ-014 SHALL have port mb_cnt, output, 20 bits: number of MBs completed in the current frame.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last MB is saved.

Function
REQ-017 SHALL implement one-hot states IDLE, PREP, REQ, RUN, SAVE and DONE.
REQ-018 SHALL, in IDLE, on start with mb_w!=0 and mb_h!=0:
  - latch w1=mb_w-1, w2=mb_w-2, h1=mb_h-1;
  - clear x, y and mb_cnt;
  - go to PREP.
REQ-019 SHALL ignore start in IDLE when mb_w==0 or mb_h==0: no state change, no output change.
REQ-020 SHALL ignore start in any state other than IDLE.
REQ-021 SHALL compute w1, w2 and h1 modulo 2^10; mb_w==1 gives w2=10'h3FF.
REQ-022 SHALL stay in PREP for exactly PREP_CYC cycles, then go to REQ.
REQ-023 SHALL assert mb_req throughout REQ and hold x,y stable until mb_ack is sampled high.
REQ-024 SHALL go from REQ to RUN on mb_ack; on mb_ack and mb_done in the same cycle, SHALL go directly to SAVE.
REQ-025 SHALL stay in RUN until mb_done, then go to SAVE.
REQ-026 SHALL ignore mb_done in IDLE, PREP, DONE and SAVE.
REQ-027 SHALL, in SAVE, assert sb_load for exactly one cycle with x,y still equal to the just-finished MB, and increment mb_cnt.
REQ-028 SHALL, after SAVE, advance position:
  - if x!=w1, increment x;
  - else set x=0 and increment y.
  The new x,y SHALL be visible on the cycle after SAVE.
REQ-029 SHALL go from SAVE to DONE when x==w1 and y==h1; otherwise SHALL go to PREP, re-running the PREP_CYC wait for the next boundary fetch.
REQ-030 SHALL, in DONE:
  - pulse frame_done for one cycle;
  - leave x,y at the last MB;
  - return to IDLE on the next cycle.
REQ-031 SHALL, on abort in any non-IDLE state, enter IDLE on the next edge with mb_req, sb_load and frame_done low.
REQ-032 SHALL give abort priority over mb_ack and mb_done in the same cycle; mb_cnt SHALL keep its value.
REQ-033 SHALL drive mb_req and sb_load as registered outputs, glitch-free.
REQ-034 SHALL, for a frame of N=mb_w*mb_h MBs, produce exactly N mb_req grants, N sb_load pulses and one frame_done.

Reset
REQ-035 SHALL, while rst_n is low:
  - hold state IDLE;
  - drive x, y, w1, w2, h1 and mb_cnt to 0;
  - drive mb_req, sb_load, busy and frame_done to 0.
REQ-036 SHALL, on reset assertion mid-frame, abandon the frame immediately, with no sb_load or frame_done afterwards.

Verification
REQ-037 SHALL cover scenario "2x2 frame":
  - stimulus: mb_w=2, mb_h=2, start; mb_ack 1 cycle after mb_req; mb_done 5 cycles later.
  - response: x,y sequence (0,0),(1,0),(0,1),(1,1); four sb_load pulses; frame_done once; mb_cnt=4; w1=1, w2=0, h1=1.
REQ-038 SHALL cover scenario "single column":
  - stimulus: mb_w=1, mb_h=3.
  - response: w2=10'h3FF; x stays 0; y steps 0,1,2; three sb_load pulses.
REQ-039 SHALL cover scenario "timing and handshake":
  - stimulus: start at cycle 0; mb_ack delayed 7 cycles; mb_ack and mb_done together on one MB.
  - response: mb_req first high at cycle 1+PREP_CYC=4; mb_req held stable until ack; REQ goes straight to SAVE when ack and done coincide.
REQ-040 SHALL cover scenario "zero dimension and busy start":
  - stimulus: start with mb_h=0; start asserted while busy.
  - response: busy stays 0 for the zero dimension; start during busy has no effect.
REQ-041 SHALL cover scenario "abort in RUN":
  - stimulus: abort on the same cycle as mb_done.
  - response: IDLE next cycle; no sb_load; no frame_done; mb_cnt unchanged.
REQ-042 SHALL cover scenario "reset mid-frame":
  - stimulus: rst_n low during SAVE, then start a new 1x1 frame.
  - response: all outputs at reset values; the new frame completes normally.
